// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the configuration-register responder.
// Also holds the byte-lane merge helper used by the register bank and read forwarding.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RWAIT = 2'b01,
    ST_ERR1  = 2'b10,
    ST_ERR2  = 2'b11
  } rsp_state_e;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps HSIZE and the low address bits to an 8-lane write strobe plus an alignment flag.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [2:0] offs,
  output logic [7:0] strb,
  output logic       aligned
);

  logic [7:0] mask_s;
  logic [2:0] amask_s;
  logic       size_ok_s;

  // Lane mask and alignment mask per transfer size; sizes above a doubleword have none
  always_comb begin
    mask_s    = 8'h00;
    amask_s   = 3'b000;
    size_ok_s = 1'b1;
    case (size)
      HSIZE_BYTE:  begin mask_s = 8'h01; amask_s = 3'b000; end
      HSIZE_HALF:  begin mask_s = 8'h03; amask_s = 3'b001; end
      HSIZE_WORD:  begin mask_s = 8'h0F; amask_s = 3'b011; end
      HSIZE_DWORD: begin mask_s = 8'hFF; amask_s = 3'b111; end
      default:     begin mask_s = 8'h00; amask_s = 3'b000; size_ok_s = 1'b0; end
    endcase
  end

  assign strb    = mask_s << offs;
  assign aligned = size_ok_s && ((offs & amask_s) == 3'b000);

endmodule

// File: rtl/ahb_cfg_regs.sv
// AHB-Lite responder holding NUM_REGS-1 RW config registers plus one read-only status word.
// Optional write lock via reg0 bit 0 when AHB_CFG_LOCK_EN is defined.
module ahb_cfg_regs
  import ahb_pkg::*;
#(
  parameter int          AWIDTH    = 32,
  parameter int          DWIDTH    = 64,
  parameter int          NUM_REGS  = 8,
  parameter int          WIN_BITS  = 12,
  parameter int          RD_WAIT   = 1,
  parameter logic [63:0] RESET_VAL = 64'h0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sel,
  input  logic [AWIDTH-1:0]              addr,
  input  logic                           write,
  input  logic [2:0]                     size,
  input  logic [1:0]                     trans,
  input  logic                           ready,
  input  logic [DWIDTH-1:0]              wdata,
  output logic                           ready_out,
  output logic                           resp,
  output logic [DWIDTH-1:0]              rdata,
  output logic [(NUM_REGS-1)*DWIDTH-1:0] cfg_o,
  input  logic [DWIDTH-1:0]              sts_i
);

  localparam int IDXW = WIN_BITS - 3;

  rsp_state_e        state_r, nxt_state_s;
  logic              ready_r, nxt_ready_s;
  logic              resp_r, nxt_resp_s;
  logic [DWIDTH-1:0] rdata_r, nxt_rdata_s;
  logic [2:0]        cnt_r, nxt_cnt_s;
  logic [IDXW-1:0]   rd_idx_r, nxt_rd_idx_s;
  logic              wr_pend_r, nxt_wr_pend_s;
  logic [IDXW-1:0]   wr_idx_r, nxt_wr_idx_s;
  logic [7:0]        wr_strb_r, nxt_wr_strb_s;
  logic [DWIDTH-1:0] regs_r [NUM_REGS-1];

  logic              acc_s, err_s, lock_err_s, aligned_s;
  logic [7:0]        strb_s;
  logic [IDXW-1:0]   idx_s, rd_idx_s;
  logic [DWIDTH-1:0] rd_val_s;
  logic              unused_s;

  assign unused_s = ^addr[AWIDTH-1:WIN_BITS];
  assign idx_s    = addr[WIN_BITS-1:3];
  assign acc_s    = sel && ready && ready_r &&
                    ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

  ahb_byte_strobe u_strobe (
    .size    (size),
    .offs    (addr[2:0]),
    .strb    (strb_s),
    .aligned (aligned_s)
  );

`ifdef AHB_CFG_LOCK_EN
  logic lock_s;
  // Lock bit is forwarded from a reg0 write still in its data phase
  assign lock_s = (wr_pend_r && (wr_idx_r == {IDXW{1'b0}}) && wr_strb_r[0]) ? wdata[0]
                                                                            : regs_r[0][0];
  assign lock_err_s = write && lock_s && (idx_s != {IDXW{1'b0}}) &&
                      (idx_s < IDXW'(NUM_REGS - 1));
`else
  assign lock_err_s = 1'b0;
`endif

  assign err_s = (idx_s >= IDXW'(NUM_REGS)) || (size > HSIZE_DWORD) || !aligned_s ||
                 (write && (idx_s == IDXW'(NUM_REGS - 1))) || lock_err_s;

  assign rd_idx_s = (state_r == ST_RWAIT) ? rd_idx_r : idx_s;

  // Read mux with forwarding of an overlapping write data phase
  always_comb begin
    rd_val_s = {DWIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      rd_val_s = (rd_idx_s == IDXW'(i)) ? regs_r[i] : rd_val_s;
    end
    rd_val_s = (rd_idx_s == IDXW'(NUM_REGS - 1)) ? sts_i : rd_val_s;
    rd_val_s = (wr_pend_r && (wr_idx_r == rd_idx_s)) ? byte_merge(rd_val_s, wdata, wr_strb_r)
                                                     : rd_val_s;
  end

  // Responder FSM next state and next registered bus outputs
  always_comb begin
    nxt_state_s   = state_r;
    nxt_ready_s   = 1'b1;
    nxt_resp_s    = HRESP_OKAY;
    nxt_rdata_s   = {DWIDTH{1'b0}};
    nxt_cnt_s     = cnt_r;
    nxt_rd_idx_s  = rd_idx_r;
    nxt_wr_pend_s = 1'b0;
    nxt_wr_idx_s  = wr_idx_r;
    nxt_wr_strb_s = wr_strb_r;
    case (state_r)
      ST_RWAIT: begin
        if (cnt_r <= 3'd1) begin
          nxt_state_s = ST_IDLE;
          nxt_rdata_s = rd_val_s;
          nxt_cnt_s   = 3'd0;
        end else begin
          nxt_ready_s = 1'b0;
          nxt_cnt_s   = cnt_r - 3'd1;
        end
      end
      ST_ERR1: begin
        nxt_state_s = ST_ERR2;
        nxt_resp_s  = HRESP_ERROR;
      end
      ST_IDLE, ST_ERR2: begin
        nxt_state_s = ST_IDLE;
        if (acc_s) begin
          if (err_s) begin
            nxt_state_s = ST_ERR1;
            nxt_ready_s = 1'b0;
            nxt_resp_s  = HRESP_ERROR;
          end else if (write) begin
            nxt_wr_pend_s = 1'b1;
            nxt_wr_idx_s  = idx_s;
            nxt_wr_strb_s = strb_s;
          end else if (RD_WAIT == 0) begin
            nxt_rdata_s = rd_val_s;
          end else begin
            nxt_state_s  = ST_RWAIT;
            nxt_cnt_s    = 3'(RD_WAIT);
            nxt_rd_idx_s = idx_s;
            nxt_ready_s  = 1'b0;
          end
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      default: nxt_state_s = ST_IDLE;
    endcase
  end

  // FSM state and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      resp_r    <= HRESP_OKAY;
      rdata_r   <= {DWIDTH{1'b0}};
      cnt_r     <= 3'd0;
      rd_idx_r  <= {IDXW{1'b0}};
      wr_pend_r <= 1'b0;
      wr_idx_r  <= {IDXW{1'b0}};
      wr_strb_r <= 8'h00;
    end else begin
      state_r   <= nxt_state_s;
      ready_r   <= nxt_ready_s;
      resp_r    <= nxt_resp_s;
      rdata_r   <= nxt_rdata_s;
      cnt_r     <= nxt_cnt_s;
      rd_idx_r  <= nxt_rd_idx_s;
      wr_pend_r <= nxt_wr_pend_s;
      wr_idx_r  <= nxt_wr_idx_s;
      wr_strb_r <= nxt_wr_strb_s;
    end
  end

  // Register bank commits on the edge that completes a write data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs_r[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (wr_pend_r && (wr_idx_r == IDXW'(i))) begin
          regs_r[i] <= byte_merge(regs_r[i], wdata, wr_strb_r);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_cfg
    assign cfg_o[g*DWIDTH +: DWIDTH] = regs_r[g];
  end

  assign ready_out = ready_r;
  assign resp      = resp_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_ahb_cfg_regs.sv
// Directed bench for ahb_cfg_regs with hand-computed expectations (default parameters, RD_WAIT=1).
// Exercises the lock path when AHB_CFG_LOCK_EN is defined.
module tb_ahb_cfg_regs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel;
  logic [31:0]  addr;
  logic         write;
  logic [2:0]   size;
  logic [1:0]   trans;
  logic         ready;
  logic [63:0]  wdata;
  logic         ready_out;
  logic         resp;
  logic [63:0]  rdata;
  logic [447:0] cfg_o;
  logic [63:0]  sts_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign ready = ready_out;

  ahb_cfg_regs dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .write(write), .size(size),
    .trans(trans), .ready(ready), .wdata(wdata), .ready_out(ready_out), .resp(resp),
    .rdata(rdata), .cfg_o(cfg_o), .sts_i(sts_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic w, input logic [31:0] a, input logic [2:0] sz);
    sel = 1'b1; addr = a; write = w; size = sz; trans = 2'b10;
  endtask

  task automatic idle_bus;
    sel = 1'b0; trans = 2'b00; write = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d);
    ap(1'b1, a, sz);
    tick;
    idle_bus;
    wdata = d;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; addr = 32'h0; write = 1'b0; size = 3'd0;
    trans = 2'b00; wdata = 64'h0; sts_i = 64'h0;
    #12;
    chk("rst_ready", {63'd0, ready_out}, 64'd1);
    chk("rst_resp", {63'd0, resp}, 64'd0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_reg1", cfg_o[127:64], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // read idx 2: one wait state then OKAY with zero data
    ap(1'b0, 32'h10, 3'd3);
    tick;
    idle_bus;
    chk("rd2_wait_ready", {63'd0, ready_out}, 64'd0);
    tick;
    chk("rd2_ready", {63'd0, ready_out}, 64'd1);
    chk("rd2_resp", {63'd0, resp}, 64'd0);
    chk("rd2_rdata", rdata, 64'h0);

    // write idx 1 with back-to-back read of the same register
    ap(1'b1, 32'h08, 3'd3);
    tick;
    wdata = 64'hDEAD_BEEF_0123_4567;
    ap(1'b0, 32'h08, 3'd3);
    chk("wr1_dphase_ready", {63'd0, ready_out}, 64'd1);
    tick;
    idle_bus;
    chk("wr1_cfg", cfg_o[127:64], 64'hDEAD_BEEF_0123_4567);
    chk("b2b_wait_ready", {63'd0, ready_out}, 64'd0);
    tick;
    chk("b2b_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
    chk("b2b_resp", {63'd0, resp}, 64'd0);
    tick;
    chk("rdata_idle_zero", rdata, 64'h0);

    // byte-lane writes
    do_write(32'h08, 3'd3, 64'h0);
    do_write(32'h0B, 3'd0, 64'h1111_1111_A511_1111);
    chk("byte_wr_reg1", cfg_o[127:64], 64'h0000_0000_A500_0000);
    do_write(32'h14, 3'd2, 64'hCAFE_F00D_2222_2222);
    chk("word_wr_reg2", cfg_o[191:128], 64'hCAFE_F00D_0000_0000);
    do_write(32'h0C, 3'd1, 64'h3333_BEEF_3333_3333);
    chk("half_wr_reg1", cfg_o[127:64], 64'h0000_BEEF_A500_0000);

    // misaligned halfword write: two-cycle ERROR, register untouched
    ap(1'b1, 32'h09, 3'd1);
    tick;
    idle_bus;
    wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("mis_err1_ready", {63'd0, ready_out}, 64'd0);
    chk("mis_err1_resp", {63'd0, resp}, 64'd1);
    tick;
    chk("mis_err2_ready", {63'd0, ready_out}, 64'd1);
    chk("mis_err2_resp", {63'd0, resp}, 64'd1);
    tick;
    chk("mis_after_resp", {63'd0, resp}, 64'd0);
    chk("mis_reg1_kept", cfg_o[127:64], 64'h0000_BEEF_A500_0000);

    // status register read
    sts_i = 64'h1234;
    ap(1'b0, 32'h38, 3'd3);
    tick;
    idle_bus;
    tick;
    chk("sts_rdata", rdata, 64'h1234);
    chk("sts_resp", {63'd0, resp}, 64'd0);

    // write to status register is an error
    ap(1'b1, 32'h38, 3'd3);
    tick;
    idle_bus;
    chk("sts_wr_err1", {62'd0, ready_out, resp}, 64'd1);
    tick;
    chk("sts_wr_err2", {62'd0, ready_out, resp}, 64'd3);
    tick;

    // out-of-range index and oversize transfer are errors
    ap(1'b0, 32'h40, 3'd3);
    tick;
    idle_bus;
    chk("oor_err1", {62'd0, ready_out, resp}, 64'd1);
    tick;
    tick;
    ap(1'b0, 32'h10, 3'd4);
    tick;
    idle_bus;
    chk("size4_err1", {62'd0, ready_out, resp}, 64'd1);
    tick;
    tick;

    // IDLE transfer with sel high: no access, OKAY with zero wait
    sel = 1'b1; addr = 32'h10; write = 1'b0; size = 3'd3; trans = 2'b00;
    tick;
    idle_bus;
    chk("htrans_idle", {62'd0, ready_out, resp}, 64'd2);

`ifdef AHB_CFG_LOCK_EN
    do_write(32'h00, 3'd3, 64'h1);
    ap(1'b1, 32'h18, 3'd3);
    tick;
    idle_bus;
    wdata = 64'h5555_6666_7777_8888;
    chk("lock_err1", {62'd0, ready_out, resp}, 64'd1);
    tick;
    tick;
    chk("lock_reg3_kept", cfg_o[255:192], 64'h0);
    do_write(32'h00, 3'd3, 64'h0);
    ap(1'b1, 32'h18, 3'd3);
    tick;
    idle_bus;
    wdata = 64'h5555_6666_7777_8888;
    chk("unlock_okay", {62'd0, ready_out, resp}, 64'd2);
    tick;
    chk("unlock_reg3", cfg_o[255:192], 64'h5555_6666_7777_8888);
`else
    do_write(32'h00, 3'd3, 64'h1);
    chk("reg0_bit0", cfg_o[63:0], 64'h1);
    ap(1'b1, 32'h18, 3'd3);
    tick;
    idle_bus;
    wdata = 64'h5555_6666_7777_8888;
    chk("nolock_okay", {62'd0, ready_out, resp}, 64'd2);
    tick;
    chk("nolock_reg3", cfg_o[255:192], 64'h5555_6666_7777_8888);
`endif

    // async reset in the middle of a read wait state
    ap(1'b0, 32'h08, 3'd3);
    tick;
    idle_bus;
    chk("pre_rst_wait", {63'd0, ready_out}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {63'd0, ready_out}, 64'd1);
    chk("mid_rst_reg1", cfg_o[127:64], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
